// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared types for the common-data-bus arbiter slice: the CDB
//                broadcast packet, the branch mask and the branch-resolution
//                task, plus a small index-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int c_BR_MASK_W = 4;
    localparam int c_REG_IDX_W = 6;
    localparam int c_VALUE_W   = 32;

    typedef logic [c_BR_MASK_W-1:0] BR_MASK;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } BR_TASK;

    typedef struct packed {
        logic                   valid;
        logic [c_REG_IDX_W-1:0] reg_idx;
        logic [c_VALUE_W-1:0]   value;
    } CDB_PACKET;

    // Width of an index into n items, never narrower than one bit.
    function automatic int f_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_psel.sv
`default_nettype none
// ============================================================================
//  Module      : rr_psel
//  Description : Rotating multi-grant selector. Grants up to REQS of the WIDTH
//                request bits, scanning upward from ptr with wrap-around.
//                Implemented as rotate -> priority select -> rotate back.
//  Ports       : req       - request vector
//                ptr       - scan start index
//                grant     - REQS one-hot vectors, grant[k] is the k-th grant
//                last_idx  - index of the last grant issued in scan order
//                any_grant - at least one grant issued
//  Revision    : 1.0  initial release
// ============================================================================
module rr_psel
    import cdb_arbiter_pkg::*;
#(
    parameter int  WIDTH = 4,
    parameter int  REQS  = 2,
    localparam int c_IW  = f_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0]           req,
    input  logic [c_IW-1:0]            ptr,
    output logic [REQS-1:0][WIDTH-1:0] grant,
    output logic [c_IW-1:0]            last_idx,
    output logic                       any_grant
);

    function automatic logic [c_IW-1:0] f_wrap(input int a);
        return c_IW'(a % WIDTH);
    endfunction

    logic [WIDTH-1:0]            w_rot;
    logic [WIDTH-1:0]            w_rem;
    logic [REQS-1:0][WIDTH-1:0]  w_rgnt;
    logic [c_IW-1:0]             w_last_rot;
    logic                        w_found;
    logic                        w_any;

    // Rotate so that position 0 is the pointer, then peel off the lowest set
    // bit REQS times. Scan order equals rotated index order, so the last bit
    // peeled is the last grant.
    always_comb begin
        w_rot      = '0;
        w_rgnt     = '0;
        w_last_rot = '0;
        w_found    = 1'b0;
        w_any      = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            w_rot[j] = req[f_wrap(j + int'(ptr))];
        end
        w_rem = w_rot;
        for (int k = 0; k < REQS; k++) begin
            w_found = 1'b0;
            for (int j = 0; j < WIDTH; j++) begin
                if (!w_found && w_rem[j]) begin
                    w_rgnt[k][j] = 1'b1;
                    w_rem[j]     = 1'b0;
                    w_found      = 1'b1;
                    w_last_rot   = c_IW'(j);
                    w_any        = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int k = 0; k < REQS; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                grant[k][f_wrap(j + int'(ptr))] = w_rgnt[k][j];
            end
        end
    end

    assign last_idx  = f_wrap(int'(w_last_rot) + int'(ptr));
    assign any_grant = w_any;

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Shares the N-lane common data bus between NUM_REQ functional
//                units. Each FU result lands in a one-entry holding buffer;
//                up to N buffered results are broadcast per cycle in
//                round-robin order. Ungranted full buffers stall their FU.
//                Branch resolution squashes or mask-clears buffered results.
//  Ports       : clock, reset  - clock, synchronous active-high reset
//                fu_results    - per-FU offered result (.valid qualifies)
//                fu_b_mask     - per-FU branch mask of the offered result
//                br_id, br_task- resolving branch (one-hot) and its action
//                cdb_out       - broadcast lanes, lane 0 first, unused = 0
//                fu_stall      - buffer full and not granted this cycle
//                num_pending   - registered count of occupied buffers
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int  N       = 2,
    parameter int  NUM_REQ = 4,
    localparam int c_PW    = f_idx_w(NUM_REQ),
    localparam int c_CW    = $clog2(NUM_REQ + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  CDB_PACKET [NUM_REQ-1:0]   fu_results,
    input  BR_MASK    [NUM_REQ-1:0]   fu_b_mask,
    input  BR_MASK                    br_id,
    input  BR_TASK                    br_task,
    output CDB_PACKET [N-1:0]         cdb_out,
    output logic      [NUM_REQ-1:0]   fu_stall,
    output logic      [c_CW-1:0]      num_pending
);

    logic      [NUM_REQ-1:0]       r_buf_valid;
    CDB_PACKET [NUM_REQ-1:0]       r_buf_pkt;
    BR_MASK    [NUM_REQ-1:0]       r_buf_mask;
    logic      [c_PW-1:0]          r_rr_ptr;
    logic      [c_CW-1:0]          r_num_pending;

    logic      [NUM_REQ-1:0]       w_squash_hit;
    logic      [NUM_REQ-1:0]       w_elig;
    logic      [N-1:0][NUM_REQ-1:0] w_gnt;
    logic      [NUM_REQ-1:0]       w_grant;
    logic      [c_PW-1:0]          w_last_idx;
    logic                          w_any_grant;
    logic      [NUM_REQ-1:0]       w_drop;
    logic      [NUM_REQ-1:0]       w_capture;
    BR_MASK                        w_keep_mask;
    logic      [NUM_REQ-1:0]       w_next_valid;
    CDB_PACKET [NUM_REQ-1:0]       w_next_pkt;
    BR_MASK    [NUM_REQ-1:0]       w_next_mask;
    logic      [c_CW-1:0]          w_next_count;
    logic      [c_PW-1:0]          w_next_ptr;

    // A squash takes priority over a grant: a squashed entry is neither
    // eligible for the bus nor stalled, it simply frees up.
    always_comb begin
        w_squash_hit = '0;
        w_drop       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_squash_hit[i] = (br_task == SQUASH) && ((r_buf_mask[i] & br_id) != '0);
            w_drop[i]       = (br_task == SQUASH) && ((fu_b_mask[i] & br_id) != '0);
        end
    end

    assign w_elig = r_buf_valid & ~w_squash_hit;

    rr_psel #(
        .WIDTH (NUM_REQ),
        .REQS  (N)
    ) u_rr_psel (
        .req       (w_elig),
        .ptr       (r_rr_ptr),
        .grant     (w_gnt),
        .last_idx  (w_last_idx),
        .any_grant (w_any_grant)
    );

    always_comb begin
        w_grant = '0;
        cdb_out = '0;
        for (int k = 0; k < N; k++) begin
            w_grant = w_grant | w_gnt[k];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[k][i]) begin
                    cdb_out[k] = r_buf_pkt[i];
                end
            end
        end
    end

    assign fu_stall = r_buf_valid & ~w_grant & ~w_squash_hit;

    // Buffer update. The stall term only depends on registered state and the
    // branch inputs, so a buffer drained this cycle refills in the same cycle.
    always_comb begin
        w_keep_mask  = (br_task == CLEAR) ? ~br_id : '1;
        w_capture    = '0;
        w_next_valid = '0;
        w_next_pkt   = r_buf_pkt;
        w_next_mask  = r_buf_mask;
        w_next_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_capture[i] = fu_results[i].valid & ~fu_stall[i] & ~w_drop[i];
            if (w_capture[i]) begin
                w_next_valid[i] = 1'b1;
                w_next_pkt[i]   = fu_results[i];
                w_next_mask[i]  = fu_b_mask[i] & w_keep_mask;
            end else if (fu_stall[i]) begin
                w_next_valid[i] = 1'b1;
                w_next_mask[i]  = r_buf_mask[i] & w_keep_mask;
            end
            w_next_count = w_next_count + c_CW'(w_next_valid[i]);
        end
    end

    always_comb begin
        w_next_ptr = r_rr_ptr;
        if (w_any_grant) begin
            w_next_ptr = (int'(w_last_idx) == NUM_REQ - 1) ? '0 : w_last_idx + c_PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf_valid   <= '0;
            r_buf_pkt     <= '0;
            r_buf_mask    <= '0;
            r_rr_ptr      <= '0;
            r_num_pending <= '0;
        end else begin
            r_buf_valid   <= w_next_valid;
            r_buf_pkt     <= w_next_pkt;
            r_buf_mask    <= w_next_mask;
            r_rr_ptr      <= w_next_ptr;
            r_num_pending <= w_next_count;
        end
    end

    assign num_pending = r_num_pending;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter (N=2, NUM_REQ=4).
//                Directed scenarios followed by random traffic, all compared
//                each cycle against a behavioural buffer/round-robin model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N       = 2;
    localparam int NUM_REQ = 4;
    localparam int CW      = $clog2(NUM_REQ + 1);

    logic                     clock = 1'b0;
    logic                     reset;
    CDB_PACKET [NUM_REQ-1:0]  fu_results;
    BR_MASK    [NUM_REQ-1:0]  fu_b_mask;
    BR_MASK                   br_id;
    BR_TASK                   br_task;
    CDB_PACKET [N-1:0]        cdb_out;
    logic      [NUM_REQ-1:0]  fu_stall;
    logic      [CW-1:0]       num_pending;

    always #5 clock = ~clock;

    cdb_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
        .clock       (clock),
        .reset       (reset),
        .fu_results  (fu_results),
        .fu_b_mask   (fu_b_mask),
        .br_id       (br_id),
        .br_task     (br_task),
        .cdb_out     (cdb_out),
        .fu_stall    (fu_stall),
        .num_pending (num_pending)
    );

    // Reference model: one slot per FU, a scan pointer, a pending count.
    logic      m_valid [NUM_REQ];
    CDB_PACKET m_pkt   [NUM_REQ];
    BR_MASK    m_mask  [NUM_REQ];
    int        m_ptr;
    int        m_pend;

    // Observed-traffic statistics.
    int                  obs_cnt [NUM_REQ];
    int                  last_g  [NUM_REQ];
    int                  max_gap;
    int                  cyc;
    logic [NUM_REQ-1:0]  stall_seen;

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            m_valid[i] = 1'b0;
            m_pkt[i]   = '0;
            m_mask[i]  = '0;
        end
        m_ptr  = 0;
        m_pend = 0;
    endtask

    task automatic clear_inputs();
        fu_results = '0;
        fu_b_mask  = '0;
        br_id      = '0;
        br_task    = NOTHING;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NUM_REQ; i++) begin
            obs_cnt[i] = 0;
            last_g[i]  = cyc;
        end
        max_gap    = 0;
        stall_seen = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic offer(input int i, input logic [3:0] seq, input BR_MASK m);
        CDB_PACKET p;
        logic [1:0] id;
        id        = i[1:0];
        p.valid   = 1'b1;
        p.reg_idx = {id, seq};
        p.value   = $urandom;
        fu_results[i] = p;
        fu_b_mask[i]  = m;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, advance the
    // model by the buffering rules, then cross the edge and clear the inputs.
    task automatic step();
        int                  g[$];
        int                  idx;
        int                  f;
        logic [NUM_REQ-1:0]  sq;
        logic [NUM_REQ-1:0]  gv;
        logic [NUM_REQ-1:0]  st;
        CDB_PACKET           exp_lane;
        BR_MASK              keep;
        @(negedge clock);
        sq = '0;
        gv = '0;
        st = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sq[i] = (br_task == SQUASH) && ((m_mask[i] & br_id) != '0);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (m_valid[idx] && !sq[idx] && g.size() < N) begin
                g.push_back(idx);
                gv[idx] = 1'b1;
            end
        end
        for (int l = 0; l < N; l++) begin
            if (l < g.size()) exp_lane = m_pkt[g[l]];
            else              exp_lane = '0;
            chk($sformatf("lane%0d", l), cdb_out[l], exp_lane);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            st[i] = m_valid[i] && !sq[i] && !gv[i];
        end
        chk("fu_stall", fu_stall, st);
        chk("num_pending", num_pending, m_pend);
        chk("rr_ptr", dut.r_rr_ptr, m_ptr);

        for (int l = 0; l < N; l++) begin
            if (cdb_out[l].valid) begin
                f = int'(cdb_out[l].reg_idx[5:4]);
                obs_cnt[f]++;
                if (cyc - last_g[f] > max_gap) max_gap = cyc - last_g[f];
                last_g[f] = cyc;
            end
        end
        stall_seen = stall_seen | fu_stall;
        cyc++;

        keep = (br_task == CLEAR) ? ~br_id : '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fu_results[i].valid && !st[i] &&
                !((br_task == SQUASH) && ((fu_b_mask[i] & br_id) != '0))) begin
                m_valid[i] = 1'b1;
                m_pkt[i]   = fu_results[i];
                m_mask[i]  = fu_b_mask[i] & keep;
            end else if (st[i]) begin
                m_mask[i]  = m_mask[i] & keep;
            end else begin
                m_valid[i] = 1'b0;
            end
        end
        if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NUM_REQ;
        m_pend = 0;
        for (int i = 0; i < NUM_REQ; i++) if (m_valid[i]) m_pend++;

        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    initial begin
        cyc = 0;
        clear_stats();
        do_reset();

        // Single result, one-cycle latency to the bus.
        chk("rst_lane0", cdb_out[0], 0);
        chk("rst_stall", fu_stall, 0);
        chk("rst_pending", num_pending, 0);
        offer(0, 4'd5, 4'b0000);
        step();
        #1;
        chk("t1_reg", cdb_out[0].reg_idx, 6'd5);
        chk("t1_valid", cdb_out[0].valid, 1'b1);
        chk("t1_lane1", cdb_out[1], 0);
        chk("t1_stall", fu_stall, 4'b0000);
        chk("t1_pending", num_pending, 1);
        step();

        // All four offer at once: two lanes per cycle, pointer wraps to 0.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) offer(i, 4'd1, 4'b0000);
        step();
        #1;
        chk("t2_l0", cdb_out[0].reg_idx, {2'd0, 4'd1});
        chk("t2_l1", cdb_out[1].reg_idx, {2'd1, 4'd1});
        chk("t2_stall", fu_stall, 4'b1100);
        step();
        #1;
        chk("t2_l0b", cdb_out[0].reg_idx, {2'd2, 4'd1});
        chk("t2_l1b", cdb_out[1].reg_idx, {2'd3, 4'd1});
        step();
        #1;
        chk("t2_ptr", dut.r_rr_ptr, 0);

        // One FU streaming alone at full rate.
        do_reset();
        clear_stats();
        for (int c = 0; c < 6; c++) begin
            offer(2, 4'(c), 4'b0000);
            step();
        end
        step();
        chk("t3_bcasts", obs_cnt[2], 6);
        chk("t3_nostall", stall_seen[2], 1'b0);

        // Squash of a buffered entry while another is granted.
        do_reset();
        offer(0, 4'd1, 4'b0000);
        offer(1, 4'd1, 4'b0010);
        offer(2, 4'd1, 4'b0000);
        offer(3, 4'd1, 4'b0000);
        step();
        br_task = SQUASH;
        br_id   = 4'b0010;
        offer(1, 4'd2, 4'b0010);
        #1;
        chk("t4_l0", cdb_out[0].reg_idx, {2'd0, 4'd1});
        chk("t4_l1", cdb_out[1].reg_idx, {2'd2, 4'd1});
        chk("t4_stall", fu_stall, 4'b1000);
        chk("t4_pend", num_pending, 4);
        step();
        #1;
        chk("t4_pend_after", num_pending, 1);
        chk("t4_fu3", cdb_out[0].reg_idx, {2'd3, 4'd1});
        chk("t4_l1_empty", cdb_out[1], 0);
        step();

        // CLEAR then SQUASH of the same branch: entry survives.
        do_reset();
        offer(0, 4'd1, 4'b0000);
        offer(1, 4'd1, 4'b0000);
        offer(2, 4'd3, 4'b0110);
        offer(3, 4'd1, 4'b0000);
        step();
        br_task = CLEAR;
        br_id   = 4'b0100;
        offer(0, 4'd4, 4'b0100);
        step();
        br_task = SQUASH;
        br_id   = 4'b0100;
        #1;
        chk("t5_l0", cdb_out[0].reg_idx, {2'd2, 4'd3});
        chk("t5_l1", cdb_out[1].reg_idx, {2'd3, 4'd1});
        chk("t5_stall", fu_stall, 4'b0001);
        step();
        #1;
        chk("t5_fu0", cdb_out[0].reg_idx, {2'd0, 4'd4});
        step();

        // Persistent requests: fair share and bounded wait.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) offer(i, 4'd0, 4'b0000);
        step();
        clear_stats();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NUM_REQ; i++) offer(i, 4'(c + 1), 4'b0000);
            step();
        end
        for (int i = 0; i < NUM_REQ; i++) chk($sformatf("t6_cnt%0d", i), obs_cnt[i], 4);
        chk("t6_maxgap_ok", (max_gap <= 2), 1'b1);

        // Reset with full buffers discards them.
        for (int i = 0; i < NUM_REQ; i++) offer(i, 4'd9, 4'b0000);
        do_reset();
        #1;
        chk("rst2_pending", num_pending, 0);
        chk("rst2_l0", cdb_out[0], 0);
        chk("rst2_l1", cdb_out[1], 0);
        chk("rst2_stall", fu_stall, 0);

        // Random traffic with branch activity.
        for (int c = 0; c < 400; c++) begin
            int r;
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 3) != 0) offer(i, 4'($urandom), BR_MASK'($urandom));
            end
            r = int'($urandom_range(0, 5));
            if (r == 0)      br_task = CLEAR;
            else if (r == 1) br_task = SQUASH;
            else             br_task = NOTHING;
            br_id = BR_MASK'(1) << $urandom_range(0, 3);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
